// File: rtl/mem_data_pkg.sv
// rtl/mem_data_pkg.sv - shared types and constants for the memory data buffer
package mem_data_pkg;

    localparam int MDB_WIDTH  = 32;
    localparam int MDB_ADDR_W = 32;
    localparam int MDB_BE_W   = MDB_WIDTH / 8;
    localparam int MDB_LANE_W = $clog2(MDB_BE_W);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FWD   = 3'd1,
        STALL = 3'd2,
        REQ   = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5
    } ld_state_t;

    // addr is kept word-aligned (lane bits zero) once it enters the buffer
    typedef struct packed {
        logic [MDB_ADDR_W-1:0] addr;
        logic [MDB_WIDTH-1:0]  data;
        logic [MDB_BE_W-1:0]   be;
    } st_entry_t;

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            SZ_D:    return 8;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_fifo.sv
// rtl/mem_store_fifo.sv - in-order store buffer with parallel youngest-match search
module mem_store_fifo
    import mem_data_pkg::*;
#(
    parameter int   DEPTH  = 4,
    localparam int  PTR_W  = $clog2(DEPTH),
    localparam int  CNT_W  = $clog2(DEPTH + 1),
    localparam int  WORD_W = MDB_ADDR_W - MDB_LANE_W
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 i_push,
    input  st_entry_t            i_push_entry,
    input  logic                 i_pop,
    input  logic [WORD_W-1:0]    i_srch_word,
    input  logic [MDB_BE_W-1:0]  i_srch_need,
    input  logic [PTR_W-1:0]     i_sel_idx,
    output logic [MDB_WIDTH-1:0] o_sel_data,
    output st_entry_t            o_head,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_hit_any,
    output logic                 o_hit_cover,
    output logic [PTR_W-1:0]     o_hit_idx
);

    st_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    int               w_slot;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage; reset only clears occupancy, stale slots are never read as valid
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last hit seen is the youngest one
    always_comb begin
        o_hit_any = 1'b0;
        o_hit_idx = '0;
        w_slot    = 0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = int'(r_rd_ptr) + k;
            if (w_slot >= DEPTH) w_slot = w_slot - DEPTH;
            if ((k < int'(r_count)) &&
                (r_mem[w_slot].addr[MDB_ADDR_W-1:MDB_LANE_W] == i_srch_word)) begin
                o_hit_any = 1'b1;
                o_hit_idx = PTR_W'(w_slot);
            end
        end
    end

    assign o_hit_cover = ((r_mem[o_hit_idx].be & i_srch_need) == i_srch_need);
    assign o_sel_data  = r_mem[i_sel_idx].data;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

endmodule

// File: rtl/mem_data_buffer.sv
// rtl/mem_data_buffer.sv - store buffer plus load data register sharing one cache port
module mem_data_buffer
    import mem_data_pkg::*;
#(
    parameter int  WIDTH  = MDB_WIDTH,
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = MDB_ADDR_W,
    localparam int BE_W   = WIDTH / 8,
    localparam int LANE_W = $clog2(BE_W),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [WIDTH-1:0]  st_data,
    input  logic [BE_W-1:0]   st_be,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    output logic              ld_data_valid,
    output logic [WIDTH-1:0]  ld_data,
    output logic              cache_req_valid,
    input  logic              cache_req_ready,
    output logic              cache_req_we,
    output logic [ADDR_W-1:0] cache_req_addr,
    output logic [WIDTH-1:0]  cache_req_data,
    output logic [BE_W-1:0]   cache_req_be,
    input  logic              cache_rsp_valid,
    input  logic [WIDTH-1:0]  cache_rsp_data,
    output logic [CNT_W-1:0]  sb_count
);

    ld_state_t                r_state, w_next;
    logic [ADDR_W-LANE_W-1:0] r_ld_word;
    logic [1:0]               r_ld_sz;
    logic [LANE_W-1:0]        r_ld_off;
    logic                     r_ld_signed;
    logic [PTR_W-1:0]         r_fwd_idx;
    logic [WIDTH-1:0]         r_ld_data;

    logic                     w_ld_acc, w_push, w_pop, w_full, w_empty;
    logic                     w_hit_any, w_hit_cover;
    logic [PTR_W-1:0]         w_hit_idx;
    logic [WIDTH-1:0]         w_sel_data, w_word, w_shift, w_mask, w_ext;
    logic                     w_sign;
    int                       w_bits;
    logic [1:0]               w_acc_sz, w_sz;
    logic [LANE_W-1:0]        w_acc_off, w_off;
    logic [ADDR_W-LANE_W-1:0] w_srch_word;
    logic [BE_W-1:0]          w_need;
    st_entry_t                w_push_entry, w_head;
    logic                     w_unused_st_lo;

    assign ld_ready      = (r_state == IDLE);
    assign st_ready      = !w_full;
    assign w_ld_acc      = ld_valid && ld_ready;
    assign w_push        = st_valid && st_ready;
    assign w_pop         = !w_empty && (r_state != REQ) && cache_req_ready;
    assign ld_data_valid = (r_state == RESP);
    assign ld_data       = r_ld_data;

    assign w_push_entry.addr = {st_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign w_push_entry.data = st_data;
    assign w_push_entry.be   = st_be;
    assign w_unused_st_lo    = ^st_addr[LANE_W-1:0];

    // A dword request on a 32-bit port degrades to a word; misaligned low bits are dropped
    assign w_acc_sz    = (WIDTH == 32 && ld_size == SZ_D) ? SZ_W : ld_size;
    assign w_acc_off   = ld_addr[LANE_W-1:0] & ~LANE_W'(size_bytes(w_acc_sz) - 1);
    assign w_sz        = (r_state == IDLE) ? w_acc_sz : r_ld_sz;
    assign w_off       = (r_state == IDLE) ? w_acc_off : r_ld_off;
    assign w_srch_word = (r_state == IDLE) ? ld_addr[ADDR_W-1:LANE_W] : r_ld_word;
    assign w_need      = BE_W'((1 << size_bytes(w_sz)) - 1) << w_off;

    mem_store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .clr          (clr),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_srch_word  (w_srch_word),
        .i_srch_need  (w_need),
        .i_sel_idx    (r_fwd_idx),
        .o_sel_data   (w_sel_data),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (sb_count),
        .o_hit_any    (w_hit_any),
        .o_hit_cover  (w_hit_cover),
        .o_hit_idx    (w_hit_idx)
    );

    // Lane extraction and sign/zero extension of the word being latched
    always_comb begin
        w_word  = (r_state == FWD) ? w_sel_data : cache_rsp_data;
        w_bits  = 8 * size_bytes(r_ld_sz);
        w_shift = w_word >> (int'(r_ld_off) * 8);
        w_mask  = {WIDTH{1'b1}} >> (WIDTH - w_bits);
        w_sign  = r_ld_signed && w_shift[w_bits-1];
        w_ext   = (w_shift & w_mask) | ({WIDTH{w_sign}} & ~w_mask);
    end

    // Load FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ld_acc) w_next = !w_hit_any ? REQ : (w_hit_cover ? FWD : STALL);
            FWD:     w_next = RESP;
            STALL:   if (!w_hit_any) w_next = REQ;
            REQ:     if (cache_req_ready) w_next = WAIT;
            WAIT:    if (cache_rsp_valid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Load FSM state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Load context captured at accept and result register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ld_word   <= '0;
            r_ld_sz     <= SZ_B;
            r_ld_off    <= '0;
            r_ld_signed <= 1'b0;
            r_fwd_idx   <= '0;
            r_ld_data   <= '0;
        end else begin
            if (w_ld_acc) begin
                r_ld_word   <= ld_addr[ADDR_W-1:LANE_W];
                r_ld_sz     <= w_acc_sz;
                r_ld_off    <= w_acc_off;
                r_ld_signed <= ld_signed;
                r_fwd_idx   <= w_hit_idx;
            end
            if (r_state == FWD || (r_state == WAIT && cache_rsp_valid)) begin
                r_ld_data <= w_ext;
            end
        end
    end

    // Cache port: a pending load fill outranks the store drain
    always_comb begin
        cache_req_valid = 1'b0;
        cache_req_we    = 1'b0;
        cache_req_addr  = '0;
        cache_req_data  = '0;
        cache_req_be    = '0;
        if (r_state == REQ) begin
            cache_req_valid = 1'b1;
            cache_req_addr  = {r_ld_word, {LANE_W{1'b0}}};
        end else if (!w_empty) begin
            cache_req_valid = 1'b1;
            cache_req_we    = 1'b1;
            cache_req_addr  = w_head.addr;
            cache_req_data  = w_head.data;
            cache_req_be    = w_head.be;
        end
    end

endmodule

// File: tb/tb_mem_data_buffer.sv
// tb/tb_mem_data_buffer.sv - directed self-checking bench for mem_data_buffer
module tb_mem_data_buffer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_be = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_signed = 1'b0;
    logic        ld_data_valid;
    logic [31:0] ld_data;
    logic        cache_req_valid;
    logic        cache_req_ready = 1'b0;
    logic        cache_req_we;
    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_data;
    logic [3:0]  cache_req_be;
    logic        cache_rsp_valid = 1'b0;
    logic [31:0] cache_rsp_data = '0;
    logic [2:0]  sb_count;

    int checks   = 0;
    int failures = 0;

    mem_data_buffer #(.WIDTH(32), .DEPTH(4), .ADDR_W(32)) dut (
        .clk             (clk),
        .clr             (clr),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_be           (st_be),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_size         (ld_size),
        .ld_signed       (ld_signed),
        .ld_data_valid   (ld_data_valid),
        .ld_data         (ld_data),
        .cache_req_valid (cache_req_valid),
        .cache_req_ready (cache_req_ready),
        .cache_req_we    (cache_req_we),
        .cache_req_addr  (cache_req_addr),
        .cache_req_data  (cache_req_data),
        .cache_req_be    (cache_req_be),
        .cache_rsp_valid (cache_rsp_valid),
        .cache_rsp_data  (cache_rsp_data),
        .sb_count        (sb_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_size   = sz;
        ld_signed = sgn;
        tick();
        ld_valid  = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_count", sb_count, 0);
        chk("rst_req_valid", cache_req_valid, 0);
        chk("rst_ld_valid", ld_data_valid, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_req_addr", cache_req_addr, 0);
        clr = 1'b1;
        tick();
        chk("rst_st_ready", st_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);

        // reset mid-drain
        push(32'h100, 32'h11, 4'hF);
        push(32'h104, 32'h22, 4'hF);
        push(32'h108, 32'h33, 4'hF);
        chk("drain_count3", sb_count, 3);
        chk("drain_head_addr", cache_req_addr, 32'h100);
        chk("drain_head_we", cache_req_we, 1);
        clr = 1'b0;
        settle();
        chk("midrst_count", sb_count, 0);
        chk("midrst_req_valid", cache_req_valid, 0);
        clr = 1'b1;
        tick();
        chk("midrst_ld_ready", ld_ready, 1);
        chk("midrst_st_ready", st_ready, 1);

        // fill to full, then push+pop at full
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        chk("full_st_ready", st_ready, 0);
        chk("full_count", sb_count, 4);
        chk("full_head_data", cache_req_data, 32'hA0);
        st_valid = 1'b1;
        st_addr  = 32'h210;
        st_data  = 32'hA4;
        cache_req_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        cache_req_ready = 1'b0;
        settle();
        chk("fullpp_count", sb_count, 3);
        chk("fullpp_head", cache_req_addr, 32'h204);
        cache_req_ready = 1'b1;
        tick();
        tick();
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("fullpp_drained", sb_count, 0);
        chk("fullpp_no_extra", cache_req_valid, 0);

        // forward hit, signed byte
        push(32'h1000, 32'h8899AABB, 4'hF);
        chk("fwd_store_present", cache_req_valid, 1);
        load(32'h1003, 2'd0, 1'b1);
        chk("fwd_t1_valid", ld_data_valid, 0);
        chk("fwd_t1_we", cache_req_we, 1);
        chk("fwd_t1_addr", cache_req_addr, 32'h1000);
        tick();
        chk("fwd_t2_valid", ld_data_valid, 1);
        chk("fwd_t2_data", ld_data, 32'hFFFFFF88);
        chk("fwd_t2_we", cache_req_we, 1);
        tick();
        chk("fwd_pulse_end", ld_data_valid, 0);
        chk("fwd_ld_ready", ld_ready, 1);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("fwd_drained", sb_count, 0);

        // partial conflict stalls until the store drains
        push(32'h2000, 32'h000000CC, 4'b0001);
        load(32'h2000, 2'd2, 1'b0);
        chk("stall_ld_ready", ld_ready, 0);
        chk("stall_we", cache_req_we, 1);
        chk("stall_be", cache_req_be, 4'b0001);
        tick();
        chk("stall_hold_we", cache_req_we, 1);
        chk("stall_hold_count", sb_count, 1);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("stall_exit_valid", cache_req_valid, 0);
        chk("stall_exit_ready", ld_ready, 0);
        tick();
        chk("stall_req_valid", cache_req_valid, 1);
        chk("stall_req_we", cache_req_we, 0);
        chk("stall_req_addr", cache_req_addr, 32'h2000);
        chk("stall_req_data", cache_req_data, 0);
        chk("stall_req_be", cache_req_be, 0);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("stall_wait_valid", cache_req_valid, 0);
        cache_rsp_valid = 1'b1;
        cache_rsp_data  = 32'h12345678;
        tick();
        cache_rsp_valid = 1'b0;
        chk("stall_resp_valid", ld_data_valid, 1);
        chk("stall_resp_data", ld_data, 32'h12345678);
        tick();
        chk("stall_pulse_end", ld_data_valid, 0);

        // load miss outranks buffered stores
        push(32'h3100, 32'h11, 4'hF);
        push(32'h3104, 32'h22, 4'hF);
        load(32'h3002, 2'd1, 1'b0);
        chk("prio_req_valid", cache_req_valid, 1);
        chk("prio_req_we", cache_req_we, 0);
        chk("prio_req_addr", cache_req_addr, 32'h3000);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("prio_no_pop", sb_count, 2);
        chk("prio_store_we", cache_req_we, 1);
        chk("prio_store_addr", cache_req_addr, 32'h3100);
        cache_rsp_valid = 1'b1;
        cache_rsp_data  = 32'hBEEF0000;
        tick();
        cache_rsp_valid = 1'b0;
        chk("prio_resp_valid", ld_data_valid, 1);
        chk("prio_resp_data", ld_data, 32'h0000BEEF);
        cache_req_ready = 1'b1;
        tick();
        chk("prio_drain1_count", sb_count, 1);
        chk("prio_drain1_addr", cache_req_addr, 32'h3104);
        chk("prio_drain1_data", cache_req_data, 32'h22);
        tick();
        cache_req_ready = 1'b0;
        settle();
        chk("prio_drain2_count", sb_count, 0);

        // response outside WAIT is ignored
        cache_rsp_valid = 1'b1;
        cache_rsp_data  = 32'hDEADBEEF;
        tick();
        cache_rsp_valid = 1'b0;
        tick();
        chk("stray_rsp_valid", ld_data_valid, 0);
        chk("stray_rsp_data", ld_data, 32'h0000BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
